// File: rtl/regbus_reader_pkg.sv
// Shared definitions for the register-bus read/write controllers:
// controller state encoding and default bus geometry.
package regbus_reader_pkg;

   localparam int DW_DEFAULT = 32;
   localparam int AW_DEFAULT = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2,
      ST_TURN  = 2'd3
   } bus_state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Index-to-one-hot decoder; output is all zero when disabled or when the
// index does not name one of the NREG outputs.
module onehot_decoder
   import regbus_reader_pkg::*;
#(
   parameter int NREG = 32,
   parameter int AW   = AW_DEFAULT
) (
   input  logic [AW-1:0]   idx,
   input  logic            en,
   output logic [NREG-1:0] onehot
);

   for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == AW'(gi));
   end

endmodule

// File: rtl/regbus_reader.sv
// Read controller for a bank of tristate registers on one shared bus:
// one-hot output enable, settle window, sampled response, bus turnaround gap.
module regbus_reader
   import regbus_reader_pkg::*;
#(
   parameter int NREG   = 32,
   parameter int AW     = AW_DEFAULT,
   parameter int DW     = DW_DEFAULT,
   parameter int SETTLE = 1,
   parameter int TURN   = 1
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [AW-1:0]   req_addr,
   output logic [NREG-1:0] oe,
   input  logic [DW-1:0]   bus,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_err
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int TW = (TURN > 0) ? $clog2(TURN + 1) : 1;

   bus_state_t      state, state_next;
   logic [NREG-1:0] oe_reg, oe_next;
   logic [NREG-1:0] dec;
   logic [SW-1:0]   settle_cnt, settle_next;
   logic [TW-1:0]   turn_cnt, turn_next;
   logic [DW-1:0]   data_reg, data_next;
   logic            err_reg, err_next;
   logic            valid_reg, valid_next;
   logic            accept;

   assign accept = req_valid && (state == ST_IDLE);

   // An out-of-range address decodes to all zero, which doubles as the range check.
   onehot_decoder #(
      .NREG (NREG),
      .AW   (AW)
   ) u_dec (
      .idx    (req_addr),
      .en     (accept),
      .onehot (dec)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= ST_IDLE;
         oe_reg     <= '0;
         settle_cnt <= '0;
         turn_cnt   <= '0;
         data_reg   <= '0;
         err_reg    <= 1'b0;
         valid_reg  <= 1'b0;
      end else begin
         state      <= state_next;
         oe_reg     <= oe_next;
         settle_cnt <= settle_next;
         turn_cnt   <= turn_next;
         data_reg   <= data_next;
         err_reg    <= err_next;
         valid_reg  <= valid_next;
      end
   end

   always_comb begin
      state_next  = state;
      oe_next     = oe_reg;
      settle_next = settle_cnt;
      turn_next   = turn_cnt;
      data_next   = data_reg;
      err_next    = err_reg;
      valid_next  = valid_reg;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (|dec) begin
                  oe_next     = dec;
                  settle_next = SW'(SETTLE - 1);
                  state_next  = ST_DRIVE;
               end else begin
                  // Error responses never touch the bus, so no turnaround is owed.
                  data_next  = '0;
                  err_next   = 1'b1;
                  valid_next = 1'b1;
                  turn_next  = '0;
                  state_next = ST_RESP;
               end
            end
         end
         ST_DRIVE: begin
            if (settle_cnt == '0) begin
               data_next  = bus;
               err_next   = 1'b0;
               valid_next = 1'b1;
               oe_next    = '0;
               turn_next  = TW'(TURN);
               state_next = ST_RESP;
            end else begin
               settle_next = settle_cnt - SW'(1);
            end
         end
         ST_RESP: begin
            // The turnaround gap runs down while the consumer is still busy.
            if (turn_cnt != '0) begin
               turn_next = turn_cnt - TW'(1);
            end
            if (rsp_ready) begin
               valid_next = 1'b0;
               state_next = (turn_cnt <= TW'(1)) ? ST_IDLE : ST_TURN;
            end
         end
         ST_TURN: begin
            if (turn_cnt != '0) begin
               turn_next = turn_cnt - TW'(1);
            end
            if (turn_cnt <= TW'(1)) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign req_ready = (state == ST_IDLE);
   assign oe        = oe_reg;
   assign rsp_valid = valid_reg;
   assign rsp_data  = data_reg;
   assign rsp_err   = err_reg;

endmodule

// File: tb/tb_regbus_reader.sv
// Directed bench for regbus_reader: two instances with different geometry
// (A: 32 regs, SETTLE=1, TURN=1; B: 20 regs, SETTLE=3, TURN=2) on one clock.
module tb_regbus_reader;

   logic        clk = 1'b0;
   logic        clr;

   logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
   logic [4:0]  req_addr_a;
   logic [31:0] oe_a, bus_a, rsp_data_a;

   logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
   logic [4:0]  req_addr_b;
   logic [19:0] oe_b;
   logic [31:0] bus_b, rsp_data_b;

   logic [31:0] regs [32];
   logic [31:0] bus_idle;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regbus_reader #(.NREG(32), .AW(5), .DW(32), .SETTLE(1), .TURN(1)) dut_a (
      .clk (clk), .clr (clr),
      .req_valid (req_valid_a), .req_ready (req_ready_a), .req_addr (req_addr_a),
      .oe (oe_a), .bus (bus_a),
      .rsp_valid (rsp_valid_a), .rsp_ready (rsp_ready_a),
      .rsp_data (rsp_data_a), .rsp_err (rsp_err_a)
   );

   regbus_reader #(.NREG(20), .AW(5), .DW(32), .SETTLE(3), .TURN(2)) dut_b (
      .clk (clk), .clr (clr),
      .req_valid (req_valid_b), .req_ready (req_ready_b), .req_addr (req_addr_b),
      .oe (oe_b), .bus (bus_b),
      .rsp_valid (rsp_valid_b), .rsp_ready (rsp_ready_b),
      .rsp_data (rsp_data_b), .rsp_err (rsp_err_b)
   );

   // Register bank model: the enabled register drives the bus, otherwise bus_idle.
   always_comb begin
      bus_a = bus_idle;
      for (int i = 0; i < 32; i++) if (oe_a[i]) bus_a = regs[i];
   end

   always_comb begin
      bus_b = bus_idle;
      for (int i = 0; i < 20; i++) if (oe_b[i]) bus_b = regs[i];
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (oe_a !== 32'h0) begin errors++; $display("FAIL reset_oe_a: got %h want %h", oe_a, 32'h0); end
      checks++; if (oe_b !== 20'h0) begin errors++; $display("FAIL reset_oe_b: got %h want %h", oe_b, 20'h0); end
      checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_a); end
      checks++; if (rsp_data_a !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_a); end
      checks++; if (rsp_err_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err_a); end
      clr = 1'b0;
      @(negedge clk);
      checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL reset_req_ready_a: got %b want 1", req_ready_a); end
      checks++; if (req_ready_b !== 1'b1) begin errors++; $display("FAIL reset_req_ready_b: got %b want 1", req_ready_b); end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      req_valid_a = 1'b1; req_addr_a = 5'd8;
      @(negedge clk);
      req_valid_a = 1'b0;
      checks++; if (oe_a !== 32'h0000_0100) begin errors++; $display("FAIL midrst_oe_drive: got %h want %h", oe_a, 32'h0000_0100); end
      #2 clr = 1'b1;
      #1;
      checks++; if (oe_a !== 32'h0) begin errors++; $display("FAIL midrst_oe_async: got %h want %h", oe_a, 32'h0); end
      checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid_a); end
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b want 1", req_ready_a); end
      checks++; if (oe_a !== 32'h0) begin errors++; $display("FAIL midrst_oe_after: got %h want %h", oe_a, 32'h0); end
      checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_rsp_after: got %b want 0", rsp_valid_a); end
   endtask

   task automatic test_single_read();
      regs[5] = 32'hDEAD_BEEF;
      rsp_ready_a = 1'b0;
      @(negedge clk);
      checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL single_ready_idle: got %b want 1", req_ready_a); end
      req_valid_a = 1'b1; req_addr_a = 5'd5;
      @(negedge clk);
      req_valid_a = 1'b0;
      checks++; if (oe_a !== 32'h0000_0020) begin errors++; $display("FAIL single_oe: got %h want %h", oe_a, 32'h20); end
      checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", rsp_valid_a); end
      checks++; if (req_ready_a !== 1'b0) begin errors++; $display("FAIL single_ready_busy: got %b want 0", req_ready_a); end
      @(negedge clk);
      checks++; if (oe_a !== 32'h0) begin errors++; $display("FAIL single_oe_drop: got %h want 0", oe_a); end
      checks++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid_a); end
      checks++; if (rsp_data_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want %h", rsp_data_a, 32'hDEAD_BEEF); end
      checks++; if (rsp_err_a !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", rsp_err_a); end
      $display("read a addr=5 data=%h err=%0b", rsp_data_a, rsp_err_a);
      // Backpressure: bus content changes and a stray request must both be ignored.
      regs[5] = 32'h1234_5678; bus_idle = 32'h1234_5678;
      req_valid_a = 1'b1; req_addr_a = 5'd7;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid_a); end
         checks++; if (rsp_data_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, rsp_data_a, 32'hDEAD_BEEF); end
         checks++; if (req_ready_a !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready_a); end
         checks++; if (oe_a !== 32'h0) begin errors++; $display("FAIL bp_oe[%0d]: got %h want 0", i, oe_a); end
      end
      req_valid_a = 1'b0;
      rsp_ready_a = 1'b1;
      @(negedge clk);
      rsp_ready_a = 1'b0;
      bus_idle = 32'h0;
      checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid_a); end
      checks++; if (req_ready_a !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", req_ready_a); end
   endtask

   task automatic test_throughput_a();
      logic [4:0] addrs [2];
      logic [31:0] exp [2];
      int acc_cyc [2];
      int nacc = 0;
      int nrsp = 0;
      addrs = '{5'd3, 5'd4};
      regs[3] = 32'h0303_0303; regs[4] = 32'h0404_0404;
      exp = '{32'h0303_0303, 32'h0404_0404};
      acc_cyc = '{0, 0};
      rsp_ready_a = 1'b1;
      for (int cyc = 0; cyc < 30 && nrsp < 2; cyc++) begin
         @(negedge clk);
         if (rsp_valid_a) begin
            checks++; if (rsp_data_a !== exp[nrsp]) begin errors++; $display("FAIL tput_data[%0d]: got %h want %h", nrsp, rsp_data_a, exp[nrsp]); end
            $display("read a addr=%0d data=%h err=%0b", addrs[nrsp], rsp_data_a, rsp_err_a);
            nrsp++;
         end
         req_valid_a = (nacc < 2);
         if (nacc < 2) req_addr_a = addrs[nacc];
         if (req_valid_a && req_ready_a) begin
            acc_cyc[nacc] = cyc;
            nacc++;
         end
      end
      req_valid_a = 1'b0;
      rsp_ready_a = 1'b0;
      checks++; if (nrsp !== 2) begin errors++; $display("FAIL tput_timeout: got %0d responses want 2", nrsp); end
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 3) begin errors++; $display("FAIL tput_spacing: got %0d cycles want 3", acc_cyc[1] - acc_cyc[0]); end
   endtask

   task automatic test_out_of_range();
      logic [4:0] bad [2];
      bad = '{5'd25, 5'd20};
      for (int k = 0; k < 2; k++) begin
         rsp_ready_b = 1'b0;
         @(negedge clk);
         req_valid_b = 1'b1; req_addr_b = bad[k];
         @(negedge clk);
         req_valid_b = 1'b0;
         checks++; if (rsp_valid_b !== 1'b1) begin errors++; $display("FAIL oor_valid[%0d]: got %b want 1", bad[k], rsp_valid_b); end
         checks++; if (rsp_err_b !== 1'b1) begin errors++; $display("FAIL oor_err[%0d]: got %b want 1", bad[k], rsp_err_b); end
         checks++; if (rsp_data_b !== 32'h0) begin errors++; $display("FAIL oor_data[%0d]: got %h want 0", bad[k], rsp_data_b); end
         checks++; if (oe_b !== 20'h0) begin errors++; $display("FAIL oor_oe[%0d]: got %h want 0", bad[k], oe_b); end
         $display("read b addr=%0d data=%h err=%0b", bad[k], rsp_data_b, rsp_err_b);
         rsp_ready_b = 1'b1;
         @(negedge clk);
         rsp_ready_b = 1'b0;
         checks++; if (rsp_valid_b !== 1'b0) begin errors++; $display("FAIL oor_release[%0d]: got %b want 0", bad[k], rsp_valid_b); end
         checks++; if (req_ready_b !== 1'b1) begin errors++; $display("FAIL oor_ready[%0d]: got %b want 1", bad[k], req_ready_b); end
      end
   endtask

   task automatic test_settle();
      regs[9] = 32'h0;
      rsp_ready_b = 1'b0;
      @(negedge clk);
      req_valid_b = 1'b1; req_addr_b = 5'd9;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         req_valid_b = 1'b0;
         regs[9] = 32'(i);
         checks++; if (oe_b !== 20'h00200) begin errors++; $display("FAIL settle_oe[%0d]: got %h want %h", i, oe_b, 20'h00200); end
         checks++; if (rsp_valid_b !== 1'b0) begin errors++; $display("FAIL settle_early[%0d]: got %b want 0", i, rsp_valid_b); end
      end
      @(negedge clk);
      checks++; if (oe_b !== 20'h0) begin errors++; $display("FAIL settle_oe_drop: got %h want 0", oe_b); end
      checks++; if (rsp_valid_b !== 1'b1) begin errors++; $display("FAIL settle_valid: got %b want 1", rsp_valid_b); end
      checks++; if (rsp_data_b !== 32'h3) begin errors++; $display("FAIL settle_data: got %h want %h", rsp_data_b, 32'h3); end
      $display("read b addr=9 data=%h err=%0b", rsp_data_b, rsp_err_b);
      rsp_ready_b = 1'b1;
      @(negedge clk);
      rsp_ready_b = 1'b0;
      checks++; if (req_ready_b !== 1'b0) begin errors++; $display("FAIL settle_turn_busy: got %b want 0", req_ready_b); end
      @(negedge clk);
      checks++; if (req_ready_b !== 1'b1) begin errors++; $display("FAIL settle_turn_done: got %b want 1", req_ready_b); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] addrs [3];
      logic [31:0] exp [3];
      int nacc = 0;
      int nrsp = 0;
      int zero_run = 0;
      int rises = 0;
      bit was_on = 1'b0;
      addrs = '{5'd3, 5'd4, 5'd19};
      regs[3] = 32'h3333_0003; regs[4] = 32'h4444_0004; regs[19] = 32'h1919_1919;
      exp = '{32'h3333_0003, 32'h4444_0004, 32'h1919_1919};
      rsp_ready_b = 1'b1;
      for (int cyc = 0; cyc < 60 && nrsp < 3; cyc++) begin
         @(negedge clk);
         checks++; if ($countones(oe_b) > 1) begin errors++; $display("FAIL b2b_onehot: got %h want at most one bit", oe_b); end
         if (oe_b != 20'h0) begin
            if (!was_on) begin
               if (rises > 0) begin
                  checks++; if (zero_run < 2) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want >= 2", zero_run); end
               end
               rises++;
            end
            was_on = 1'b1;
            zero_run = 0;
         end else begin
            was_on = 1'b0;
            zero_run++;
         end
         if (rsp_valid_b) begin
            checks++; if (rsp_data_b !== exp[nrsp]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", nrsp, rsp_data_b, exp[nrsp]); end
            checks++; if (rsp_err_b !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %b want 0", nrsp, rsp_err_b); end
            $display("read b addr=%0d data=%h err=%0b", addrs[nrsp], rsp_data_b, rsp_err_b);
            nrsp++;
         end
         req_valid_b = (nacc < 3);
         if (nacc < 3) req_addr_b = addrs[nacc];
         if (req_valid_b && req_ready_b) nacc++;
      end
      req_valid_b = 1'b0;
      rsp_ready_b = 1'b0;
      checks++; if (nrsp !== 3) begin errors++; $display("FAIL b2b_timeout: got %0d responses want 3", nrsp); end
      checks++; if (rises !== 3) begin errors++; $display("FAIL b2b_oe_pulses: got %0d want 3", rises); end
   endtask

   initial begin
      clr = 1'b1;
      req_valid_a = 1'b0; req_addr_a = 5'd0; rsp_ready_a = 1'b0;
      req_valid_b = 1'b0; req_addr_b = 5'd0; rsp_ready_b = 1'b0;
      bus_idle = 32'h0;
      for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | 32'(i);

      test_reset();
      test_reset_mid_read();
      test_single_read();
      test_throughput_a();
      test_out_of_range();
      test_settle();
      test_back_to_back();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
